// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (one shift-add / restoring step per clock)
// Define MULDIV_FAST_MUL_EN to resolve the four multiply ops with a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_we
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_m;
    logic [2*XLEN-1:0] r_p;

    logic              w_sa, w_sb, w_na, w_nb, w_neg, w_div0, w_ovf;
    logic [XLEN-1:0]   w_ma, w_mb, w_spec, w_qr, w_qrf, w_fix;
    logic [XLEN:0]     w_add, w_sub;
    logic [2*XLEN-1:0] w_mul_nx, w_div_nx, w_mfix;

    assign w_sa   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign w_sb   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign w_na   = w_sa && op_a[XLEN-1];
    assign w_nb   = w_sb && op_b[XLEN-1];
    assign w_ma   = w_na ? -op_a : op_a;
    assign w_mb   = w_nb ? -op_b : op_b;
    // Remainder follows the dividend sign; products and quotients follow the XOR of signs
    assign w_neg  = (funct3[2] && funct3[1]) ? w_na : (w_na ^ w_nb);
    assign w_div0 = funct3[2] && (op_b == {XLEN{1'b0}});
    assign w_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    assign w_spec = w_div0 ? (funct3[1] ? op_a : {XLEN{1'b1}}) : (funct3[1] ? {XLEN{1'b0}} : op_a);

    // r_p holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    assign w_add    = {1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, r_m};
    assign w_mul_nx = r_p[0] ? {w_add, r_p[XLEN-1:1]} : {1'b0, r_p[2*XLEN-1:1]};
    assign w_sub    = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]} - {1'b0, r_m};
    assign w_div_nx = w_sub[XLEN] ? {r_p[2*XLEN-2:0], 1'b0} : {w_sub[XLEN-1:0], r_p[XLEN-2:0], 1'b1};

    assign w_mfix = r_neg ? -r_p : r_p;
    assign w_qr   = r_op[1] ? r_p[2*XLEN-1:XLEN] : r_p[XLEN-1:0];
    assign w_qrf  = r_neg ? -w_qr : w_qr;
    assign w_fix  = r_op[2] ? w_qrf : ((r_op[1:0] == 2'b00) ? w_mfix[XLEN-1:0] : w_mfix[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod, w_fres;
    logic [XLEN-1:0]   w_fast;
    assign w_fprod = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
    assign w_fres  = w_neg ? -w_fprod : w_fprod;
    assign w_fast  = (funct3[1:0] == 2'b00) ? w_fres[XLEN-1:0] : w_fres[2*XLEN-1:XLEN];
`endif

    assign busy  = r_state != S_IDLE;
    assign done  = r_state == S_DONE;
    assign wb_we = done && (rd_out != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_m     <= '0;
            r_p     <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (r_state == S_IDLE && start) begin
            rd_out <= rd_in;
            r_op   <= funct3;
            r_neg  <= w_neg;
            r_cnt  <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!funct3[2]) begin
                result  <= w_fast;
                r_state <= S_DONE;
            end else
`endif
            if (w_div0 || w_ovf) begin
                result  <= w_spec;
                r_state <= S_DONE;
            end else begin
                r_m     <= funct3[2] ? w_mb : w_ma;
                r_p     <= {{XLEN{1'b0}}, funct3[2] ? w_ma : w_mb};
                r_state <= S_CALC;
            end
        end else if (r_state == S_CALC) begin
            r_p   <= r_op[2] ? w_div_nx : w_mul_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN - 1))
                r_state <= S_FIX;
        end else if (r_state == S_FIX) begin
            result  <= w_fix;
            r_state <= S_DONE;
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit
// Expected results are queued at issue and popped when done pulses.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk, rst, start, busy, done, wb_we;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;
    int          nvec, nerr;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          lat;
    } exp_t;
    exp_t sb[$];

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_we(wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // inj: cycle after the start edge at which a stray start is pulsed (-1 for none)
    // dinj: also pulse a stray start during the done cycle
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] er, input bit spec,
                          input int inj, input bit dinj);
        exp_t e, g;
        int n, extra;
        e.res = er;
        e.rd  = rd;
        e.we  = (rd != 5'd0);
        e.lat = (spec || (FAST && !f[2])) ? 0 : 33;
        sb.push_back(e);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 60) begin
            start = (n == inj);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        g = sb.pop_front();
        chk("latency", 32'(n), 32'(g.lat));
        chk("result", result, g.res);
        chk("rd_out", {27'd0, rd_out}, {27'd0, g.rd});
        chk("wb_we", {31'd0, wb_we}, {31'd0, g.we});
        start = dinj;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        if (inj >= 0 || dinj) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            chk("stray_start_ignored", 32'(extra), 32'd0);
            chk("result_kept", result, g.res);
        end
    endtask

    initial begin
        int extra;
        nvec = 0; nerr = 0;
        rst = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
        #7;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        #16 rst = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0, -1, 1'b0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0, -1, 1'b0);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 1'b0, -1, 1'b0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd8,  32'h40000000, 1'b0, -1, 1'b0);
        run_op(3'b001, 32'hFFFFFFFD, 32'd7,        5'd8,  32'hFFFFFFFF, 1'b0, -1, 1'b0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 1'b0, -1, 1'b0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 1'b0, -1, 1'b0);
        run_op(3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       1'b0, -1, 1'b0);
        run_op(3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        1'b0, -1, 1'b0);
        run_op(3'b101, 32'hFFFFFFF9, 32'd2,        5'd14, 32'h7FFFFFFC, 1'b0, -1, 1'b0);
        run_op(3'b100, 32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 1'b0, -1, 1'b0);
        run_op(3'b110, 32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        1'b0, -1, 1'b0);
        run_op(3'b100, 32'h64,       32'd0,        5'd17, 32'hFFFFFFFF, 1'b1, -1, 1'b0);
        run_op(3'b110, 32'h64,       32'd0,        5'd18, 32'h64,       1'b1, -1, 1'b0);
        run_op(3'b101, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 1'b1, -1, 1'b0);
        run_op(3'b111, 32'd5,        32'd0,        5'd20, 32'd5,        1'b1, -1, 1'b0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1'b1, -1, 1'b0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        1'b1, -1, 1'b0);
        run_op(3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       1'b0, -1, 1'b0);
        run_op(3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       1'b0, 10, 1'b1);

        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wb_we", {31'd0, wb_we}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd_out", {27'd0, rd_out}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);
        run_op(3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit that consumes the two source operands read from the register file (rd1/rd2) and produces a write-back triple (wb_we, rd_out, result) that drives the register file write port (we3/wa3/wd3).
- Multi-cycle: one shift-add or restoring-divide step per clock.
- Sits beside the ALU in the execute path; the control unit stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported for RV32M.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk.
- start  input  1  request pulse; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value (dividend/multiplicand).
- op_b  input  32  rs2 value (divisor/multiplier).
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  registered result, held until next accepted start.
- rd_out  output  5  registered copy of rd_in.
- wb_we  output  1  equals done AND (rd_out != 0).

Behaviour:
- Reset (rst=0): state IDLE; busy=0, done=0, wb_we=0, result=0, rd_out=0; counter and datapath registers cleared. Reset mid-operation aborts with no write-back.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E0 latches funct3, op_a, op_b, rd_in.
  - Sign handling: signed operands are converted to magnitudes. MULH treats both operands as signed. MULHSU treats only op_a as signed. DIV/REM treat both as signed.
  - Next state is CALC, or DONE for special cases.
- CALC: exactly 32 cycles; counter runs 0..31.
  - MUL: 64-bit shift-add on magnitudes.
  - DIV: restoring division, one quotient bit per cycle.
  - Exit to FIX after the count-31 cycle.
- FIX: one cycle.
  - Applies two's-complement negation to the result when the sign rule requires it. Product sign = XOR of the signed operand signs. Quotient sign = XOR of the operand signs. Remainder sign = sign of the dividend.
  - Selects the output half: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
  - Registers result and goes to DONE.
- DONE: done=1 and wb_we per rule for exactly one cycle, then IDLE.
- Normal latency: done high in the cycle after edge E0+33.
- Special cases (IDLE→DONE at E0, done high in the cycle after E0):
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- start while busy (including during DONE) is ignored and not queued. A new start is accepted in the first IDLE cycle.
- Operand inputs may change after E0 without effect.
- result and rd_out keep their last values while IDLE.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four MUL ops use a combinational 32x32→64 multiplier. They go IDLE→DONE at E0 with result registered, so done is high in the cycle after E0. Divide ops are unchanged.
- Undefined: all ops use the iterative path with 33-cycle latency; no hardware multiplier is inferred.

Test Plan:
- Reset asserted at t=0, released at an arbitrary non-edge time → all outputs 0 while rst=0. First start after release is accepted normally.
- MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 → done once, 33 cycles after the start edge (1 cycle with MULDIV_FAST_MUL_EN). Expect result=0xFFFFFFEB, rd_out=5, wb_we=1. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each with 33-cycle latency.
- DIV 0x64/0 → 0xFFFFFFFF and REM 0x64/0 → 0x64. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All four with done one cycle after start.
- rd_in=0 with MUL 3×4 → done=1, result=12, wb_we=0. A second start pulsed 10 cycles into an operation is ignored: exactly one done, result unchanged by the second operands.
- rst driven low 15 cycles into a DIV → busy=0, done never pulses. A start after release gives the correct result 33 cycles later.
